// File: rtl/neuron_mac_if.sv
// Stream-in / weight-memory / result bundle for the neuron MAC.
// slave is the MAC's view; master is the feeding side.
interface neuron_mac_if #(
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
);
  logic [dataWidth-1:0]    my_input;
  logic                    my_input_valid;
  logic                    w_ren;
  logic [addressWidth-1:0] w_radd;
  logic [dataWidth-1:0]    w_data;
  logic [2*dataWidth-1:0]  bias;
  logic [2*dataWidth-1:0]  sum;
  logic                    sum_valid;

  modport slave (
    input  my_input, my_input_valid,
    input  w_data, bias,
    output w_ren, w_radd,
    output sum, sum_valid
  );

  modport master (
    output my_input, my_input_valid,
    output w_data, bias,
    input  w_ren, w_radd,
    input  sum, sum_valid
  );
endinterface

// File: rtl/neuron_mac.sv
// Per-neuron multiply-accumulate: drives weight reads, accumulates
// saturated signed products, adds bias, pulses one sum per vector.
module neuron_mac #(
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) (
  input  logic         clk,
  input  logic         rst,
  neuron_mac_if.slave  bus
);
  localparam int PW = 2 * dataWidth;
  localparam logic [addressWidth-1:0] LAST =
    addressWidth'(numWeight - 1);

  logic [addressWidth-1:0] cnt;
  logic                    tag;
  logic signed [dataWidth-1:0] in_d;
  logic signed [PW-1:0]    ext_a, ext_b;
  logic signed [PW-1:0]    mul_r, acc;
  logic                    v1, v2, v3;
  logic                    last1, last2, clr;

  function automatic logic [PW-1:0] sat_add(
    input logic [PW-1:0] a,
    input logic [PW-1:0] b
  );
    logic [PW-1:0] s;
    s = a + b;
    if (a[PW-1] == b[PW-1] && s[PW-1] != a[PW-1])
      s = a[PW-1] ? {1'b1, {(PW-1){1'b0}}}
                  : {1'b0, {(PW-1){1'b1}}};
    return s;
  endfunction

  assign bus.w_ren  = bus.my_input_valid;
  assign bus.w_radd = cnt;
  assign tag        = (cnt == LAST);

  assign ext_a = $signed({{dataWidth{in_d[dataWidth-1]}}, in_d});
  assign ext_b = $signed({{dataWidth{bus.w_data[dataWidth-1]}},
                          bus.w_data});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt           <= '0;
      in_d          <= '0;
      mul_r         <= '0;
      acc           <= '0;
      v1            <= 1'b0;
      v2            <= 1'b0;
      v3            <= 1'b0;
      last1         <= 1'b0;
      last2         <= 1'b0;
      clr           <= 1'b1;
      bus.sum       <= '0;
      bus.sum_valid <= 1'b0;
    end else begin
      v1    <= bus.my_input_valid;
      last1 <= bus.my_input_valid & tag;
      if (bus.my_input_valid) begin
        in_d <= $signed(bus.my_input);
        cnt  <= tag ? '0 : cnt + 1'b1;
      end

      mul_r <= ext_a * ext_b;
      v2    <= v1;
      last2 <= last1;

      // clr makes the first product of a vector a fresh load
      v3 <= v2 & last2;
      if (v2) begin
        acc <= clr ? mul_r : sat_add(acc, mul_r);
        clr <= last2;
      end

      bus.sum_valid <= v3;
      if (v3)
        bus.sum <= sat_add(acc, bus.bias);
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with a 4-weight neuron and
// a synchronous weight-memory model.
module tb_neuron_mac;
  localparam int NW = 4;
  localparam int AW = 3;
  localparam int DW = 16;

  typedef struct {
    string       name;
    logic [15:0] w[4];
    logic [15:0] x[4];
    logic [31:0] bias;
    int          gap;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] wmem[8];
  int          pc_q[$];
  logic [31:0] ps_q[$];

  neuron_mac_if #(.addressWidth(AW), .dataWidth(DW)) bus ();

  neuron_mac #(
    .numWeight(NW), .addressWidth(AW), .dataWidth(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk)
    if (bus.w_ren) bus.w_data <= wmem[bus.w_radd];

  always @(negedge clk)
    if (bus.sum_valid) begin
      pc_q.push_back(cyc);
      ps_q.push_back(bus.sum);
    end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic load_w(logic [15:0] w[4]);
    for (int i = 0; i < 4; i++) wmem[i] = w[i];
  endtask

  // drives one input; returns the negedge cycle it was presented on
  task automatic drive(string nm, logic [15:0] x, int addr,
                       output int c);
    @(negedge clk);
    bus.my_input       = x;
    bus.my_input_valid = 1'b1;
    #1;
    chk({nm, " w_ren/w_radd"}, {28'd0, bus.w_ren, bus.w_radd},
        {28'd0, 1'b1, 3'(addr)});
    c = cyc;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.my_input_valid = 1'b0;
      bus.my_input       = 16'hdead;
    end
  endtask

  task automatic run_vec(vec_t v);
    int c;
    load_w(v.w);
    bus.bias = v.bias;
    pc_q.delete();
    ps_q.delete();
    for (int j = 0; j < NW; j++) begin
      drive(v.name, v.x[j], j, c);
      if (j != NW - 1) idle(v.gap);
    end
    idle(8);
    chk({v.name, " pulses"}, 32'(pc_q.size()), 32'd1);
    if (pc_q.size() > 0) begin
      chk({v.name, " sum"}, ps_q[0], v.exp);
      chk({v.name, " latency"}, 32'(pc_q[0] - c), 32'd4);
    end
  endtask

  vec_t tv[6];

  initial begin
    int c1, c2, d;
    tv[0] = '{"basic", '{16'd2, 16'd3, 16'hFFFF, 16'd4},
              '{16'd1, 16'd1, 16'd1, 16'd1}, 32'd10, 0, 32'd18};
    tv[1] = '{"gap2", '{16'd2, 16'd3, 16'hFFFF, 16'd4},
              '{16'd1, 16'd1, 16'd1, 16'd1}, 32'd10, 2, 32'd18};
    tv[2] = '{"mixed", '{16'hFFFB, 16'd7, 16'd100, 16'hFFFE},
              '{16'd3, 16'hFFFC, 16'd2, 16'd10},
              32'hFFFFFFCE, 1, 32'd87};
    tv[3] = '{"possat", '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
              '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
              32'd0, 0, 32'h7FFFFFFF};
    tv[4] = '{"possat_bias", '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
              '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
              32'hC0000000, 3, 32'h3FFFFFFF};
    tv[5] = '{"negsat", '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
              '{16'h8000, 16'h8000, 16'h8000, 16'h8000},
              32'h80000000, 0, 32'h80000000};

    rst = 1'b0;
    bus.my_input       = '0;
    bus.my_input_valid = 1'b0;
    bus.w_data         = '0;
    bus.bias           = '0;
    for (int i = 0; i < 8; i++) wmem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset sum", bus.sum, 32'd0);
    chk("reset sum_valid", {31'd0, bus.sum_valid}, 32'd0);
    chk("reset w_radd", {29'd0, bus.w_radd}, 32'd0);
    chk("reset w_ren", {31'd0, bus.w_ren}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    for (int k = 0; k < 6; k++) run_vec(tv[k]);

    // two vectors back to back; addresses wrap 3 -> 0
    load_w(tv[0].w);
    bus.bias = 32'd0;
    pc_q.delete();
    ps_q.delete();
    drive("b2b0", 16'd1, 0, d);
    drive("b2b1", 16'd1, 1, d);
    drive("b2b2", 16'd1, 2, d);
    drive("b2b3", 16'd1, 3, c1);
    drive("b2b4", 16'd2, 0, d);
    drive("b2b5", 16'd0, 1, d);
    drive("b2b6", 16'd0, 2, d);
    drive("b2b7", 16'd1, 3, c2);
    idle(8);
    chk("b2b pulses", 32'(pc_q.size()), 32'd2);
    if (pc_q.size() == 2) begin
      chk("b2b sum0", ps_q[0], 32'd8);
      chk("b2b sum1", ps_q[1], 32'd8);
      chk("b2b lat0", 32'(pc_q[0] - c1), 32'd4);
      chk("b2b lat1", 32'(pc_q[1] - c2), 32'd4);
    end

    // leave a nonzero sum, then reset mid-vector
    run_vec(tv[5]);
    load_w(tv[0].w);
    bus.bias = 32'd10;
    pc_q.delete();
    drive("rst0", 16'd5, 0, d);
    drive("rst1", 16'd5, 1, d);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async sum", bus.sum, 32'd0);
    chk("async sum_valid", {31'd0, bus.sum_valid}, 32'd0);
    chk("async w_radd", {29'd0, bus.w_radd}, 32'd0);
    idle(2);
    rst = 1'b1;
    idle(6);
    chk("rst no pulse", 32'(pc_q.size()), 32'd0);
    run_vec(tv[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
